// File: rtl/dec4_to_bin14.sv
// -----------------------------------------------------------------------------
// dec4_to_bin14
//   Sequential 4-digit packed-BCD to 14-bit binary converter.
//   A start strobe captures DEC into a shadow register. The digits are then
//   folded in thousands-first by alternating multiply-by-ten and add-digit
//   steps. The result appears on BIN together with a one-cycle ok pulse,
//   nine clock edges after the start edge.
//
//   Optional feature macro: BCD_CHECK_EN
//     defined   - err is loaded with BIN and flags any shadow digit above 9
//     undefined - err is tied low and the digit checker is not built
//
// Ports
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset
//   st     in   1   start strobe; restarts the conversion from any state
//   DEC    in  16   packed BCD {D4,D3,D2,D1}, D4 = thousands
//   BIN    out 14   registered binary result, held between ok pulses
//   ok     out  1   registered one-cycle completion pulse
//   busy   out  1   registered, high while a conversion is in flight
//   err    out  1   registered invalid-digit flag
// -----------------------------------------------------------------------------
module dec4_to_bin14 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st,
  input  logic [15:0] DEC,
  output logic [13:0] BIN,
  output logic        ok,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state, state_nx;

  logic [15:0] shadow, shadow_nx;
  logic [13:0] acc, acc_nx;
  logic [2:0]  ptr, ptr_nx;
  logic        phase, phase_nx;
  logic [13:0] bin_q, bin_nx;
  logic        ok_q, ok_nx;
  logic        busy_q, busy_nx;

  logic [3:0]  digit;
  logic [13:0] acc_x10;
  logic        bcd_bad;

  // Digit selected by the pointer: ptr=4 picks thousands, ptr=1 picks units.
  always_comb begin
    digit = '0;
    case (ptr)
      3'd4:    digit = shadow[15:12];
      3'd3:    digit = shadow[11:8];
      3'd2:    digit = shadow[7:4];
      3'd1:    digit = shadow[3:0];
      default: digit = '0;
    endcase
  end

  // acc*10 as a shift-and-add, wrapping in 14 bits.
  assign acc_x10 = (acc << 3) + (acc << 1);

`ifdef BCD_CHECK_EN
  logic err_q, err_nx;

  always_comb begin
    bcd_bad = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (shadow[i*4 +: 4] > 4'd9) bcd_bad = 1'b1;
    end
  end
`else
  assign bcd_bad = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; st overrides every other transition.
  always_comb begin
    state_nx = state;
    if (st) begin
      state_nx = CONV;
    end else begin
      case (state)
        IDLE:    state_nx = IDLE;
        // The add step that consumes the units digit is the last CONV cycle.
        CONV:    state_nx = (phase && (ptr == 3'd1)) ? FIN : CONV;
        FIN:     state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Output / datapath next-value logic
  always_comb begin
    shadow_nx = shadow;
    acc_nx    = acc;
    ptr_nx    = ptr;
    phase_nx  = phase;
    bin_nx    = bin_q;
    ok_nx     = 1'b0;
    busy_nx   = busy_q;
`ifdef BCD_CHECK_EN
    err_nx    = err_q;
`endif
    if (st) begin
      shadow_nx = DEC;
      acc_nx    = '0;
      ptr_nx    = 3'd4;
      phase_nx  = 1'b0;
      busy_nx   = 1'b1;
    end else begin
      case (state)
        CONV: begin
          if (!phase) begin
            acc_nx   = acc_x10;
            phase_nx = 1'b1;
          end else begin
            acc_nx   = acc + {10'd0, digit};
            ptr_nx   = ptr - 3'd1;
            phase_nx = 1'b0;
          end
        end
        FIN: begin
          bin_nx  = acc;
          ok_nx   = 1'b1;
          busy_nx = 1'b0;
`ifdef BCD_CHECK_EN
          err_nx  = bcd_bad;
`endif
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      acc    <= '0;
      ptr    <= '0;
      phase  <= 1'b0;
      bin_q  <= '0;
      ok_q   <= 1'b0;
      busy_q <= 1'b0;
`ifdef BCD_CHECK_EN
      err_q  <= 1'b0;
`endif
    end else begin
      shadow <= shadow_nx;
      acc    <= acc_nx;
      ptr    <= ptr_nx;
      phase  <= phase_nx;
      bin_q  <= bin_nx;
      ok_q   <= ok_nx;
      busy_q <= busy_nx;
`ifdef BCD_CHECK_EN
      err_q  <= err_nx;
`endif
    end
  end

  assign BIN  = bin_q;
  assign ok   = ok_q;
  assign busy = busy_q;
`ifdef BCD_CHECK_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_dec4_to_bin14.sv
// -----------------------------------------------------------------------------
// tb_dec4_to_bin14
//   Directed stimulus for dec4_to_bin14. Each conversion expected to finish
//   pushes {BIN, err, cycle} into a queue; a negedge monitor pops and compares
//   whenever ok is seen, and flags any expected ok that never arrived.
// -----------------------------------------------------------------------------
module tb_dec4_to_bin14;

  logic        clk;
  logic        rst_n;
  logic        st;
  logic [15:0] DEC;
  logic [13:0] BIN;
  logic        ok;
  logic        busy;
  logic        err;

  int total;
  int bad;
  int cyc;

  typedef struct {
    logic [13:0] bin;
    logic        err;
    int          at;
  } exp_t;

  exp_t sb[$];

`ifdef BCD_CHECK_EN
  localparam logic ERR_12A4 = 1'b1;
`else
  localparam logic ERR_12A4 = 1'b0;
`endif

  dec4_to_bin14 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .st    (st),
    .DEC   (DEC),
    .BIN   (BIN),
    .ok    (ok),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Drive a one-cycle start; when push is set the completion is expected
  // nine edges after the start edge.
  task automatic issue(input logic [15:0] d, input logic push,
                       input logic [13:0] b, input logic e);
    exp_t x;
    DEC = d;
    st  = 1'b1;
    if (push) begin
      x.bin = b;
      x.err = e;
      x.at  = cyc + 10;
      sb.push_back(x);
    end
    @(negedge clk);
    st = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].at < cyc) begin
      total++;
      bad++;
      $display("FAIL missed_ok: got none want BIN=%0d at cycle %0d",
               sb[0].bin, sb[0].at);
      void'(sb.pop_front());
    end
    if (rst_n && ok) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ok: got ok with BIN=%0d at cycle %0d want none",
                 BIN, cyc);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("ok_cycle", cyc, x.at);
        check("bin", {18'd0, BIN}, {18'd0, x.bin});
        check("err", {31'd0, err}, {31'd0, x.err});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    st    = 1'b0;
    DEC   = '0;

    // Reset state
    idle(2);
    check("rst_bin",  {18'd0, BIN}, 0);
    check("rst_ok",   {31'd0, ok},  0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_err",  {31'd0, err}, 0);
    rst_n = 1'b1;
    idle(2);

    // Basic conversions with busy window
    issue(16'h9999, 1'b1, 14'd9999, 1'b0);
    check("busy_after_e0", {31'd0, busy}, 1);
    idle(8);
    check("busy_after_e8", {31'd0, busy}, 1);
    idle(1);
    check("busy_after_e9", {31'd0, busy}, 0);
    idle(2);

    issue(16'h0000, 1'b1, 14'd0, 1'b0);
    idle(11);
    issue(16'h4095, 1'b1, 14'd4095, 1'b0);
    idle(11);

    // DEC changed after start must not disturb the conversion
    issue(16'h1234, 1'b1, 14'd1234, 1'b0);
    DEC = 16'h5678;
    idle(11);

    // Restart at E4 aborts the first conversion
    issue(16'h1234, 1'b0, '0, 1'b0);
    idle(3);
    issue(16'h0007, 1'b1, 14'd7, 1'b0);
    idle(11);
    check("bin_hold_after_restart", {18'd0, BIN}, 7);

    // Start on the FIN exit edge: restart wins, BIN held
    issue(16'h1111, 1'b0, '0, 1'b0);
    idle(8);
    issue(16'h2222, 1'b1, 14'd2222, 1'b0);
    check("bin_hold_fin_restart", {18'd0, BIN}, 7);
    check("ok_low_fin_restart",   {31'd0, ok},  0);
    idle(11);

    // st held high keeps restarting
    DEC = 16'h0042;
    st  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("busy_st_held", {31'd0, busy}, 1);
    end
    begin
      exp_t x;
      x.bin = 14'd42;
      x.err = 1'b0;
      x.at  = cyc + 9;
      sb.push_back(x);
    end
    st = 1'b0;
    idle(11);

    // Invalid digit
    issue(16'h12A4, 1'b1, 14'd1304, ERR_12A4);
    idle(11);
    check("err_hold", {31'd0, err}, {31'd0, ERR_12A4});

    // Asynchronous reset mid-conversion
    issue(16'h1234, 1'b0, '0, 1'b0);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_bin",  {18'd0, BIN}, 0);
    check("async_rst_ok",   {31'd0, ok},  0);
    check("async_rst_busy", {31'd0, busy}, 0);
    check("async_rst_err",  {31'd0, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(15);
    check("post_rst_bin",  {18'd0, BIN}, 0);
    check("post_rst_busy", {31'd0, busy}, 0);

    idle(2);
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dec4_to_bin14.md
DEC4_TO_BIN14 -- requirements
Module: dec4_to_bin14

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 st  input  1  start strobe, sampled on each rising clk edge.
REQ-005 DEC  input  16  packed BCD {D4,D3,D2,D1}; D4 = thousands (DEC[15:12]), D1 = units (DEC[3:0]).
REQ-006 BIN  output  14  registered binary result, range 0..9999 for valid BCD.
REQ-007 ok  output  1  registered one-cycle pulse; BIN updated in the same cycle.
REQ-008 busy  output  1  registered; high while a conversion is in progress.
REQ-009 err  output  1  registered invalid-digit flag (see Configuration).

Function
REQ-010 States SHALL be IDLE, CONV and FIN; rst_n low forces IDLE.
REQ-011 When st=1 on any edge, in any state, the block SHALL do all of the following:
- capture DEC into an internal shadow register;
- clear the accumulator to 0;
- set the digit pointer to 4 and the phase bit to 0;
- set busy=1 and enter CONV.
REQ-012 st SHALL take priority over every other transition (restart semantics); an aborted conversion produces no ok pulse.
REQ-013 In CONV with phase=0, the block SHALL set acc <= acc*10, implemented as (acc<<3)+(acc<<1) in 14 bits, and set phase=1.
REQ-014 In CONV with phase=1, the block SHALL do all of the following:
- set acc <= acc + shadow digit[ptr] (digit zero-extended, 14-bit modulo sum);
- decrement ptr;
- clear phase.
REQ-015 When ptr reaches 0, the block SHALL move from CONV to FIN.
REQ-016 FIN lasts one cycle. On the edge leaving FIN (with st=0) the block SHALL do all of the following:
- BIN <= acc;
- ok <= 1 for exactly one cycle;
- busy <= 0;
- return to IDLE.
REQ-017 Latency: with st high at edge E0, ok and the new BIN SHALL be visible after edge E9; busy SHALL be high from after E0 through E8.
REQ-018 Changes on DEC after the st edge SHALL NOT affect the conversion in flight.
REQ-019 BIN and err SHALL hold their values between ok pulses; st alone SHALL NOT clear them.
REQ-020 If st=1 on the FIN exit edge, the restart SHALL win: BIN and err hold, and ok stays 0.
REQ-021 st held high continuously SHALL keep the block restarting, with busy=1 and no ok.

Reset
REQ-022 rst_n low SHALL asynchronously clear BIN, ok, busy, err, the accumulator, ptr, phase and the shadow register, and force IDLE.
REQ-023 Reset asserted mid-conversion SHALL abort it with no ok pulse.
REQ-024 After rst_n deasserts, the block SHALL wait in IDLE for st.

Configuration
REQ-025 Macro BCD_CHECK_EN defined: err SHALL be loaded together with BIN on the ok edge.
- err = 1 if any shadow digit exceeds 9, else 0.
- BIN still carries the modulo-2^14 weighted sum.
REQ-026 Macro BCD_CHECK_EN undefined: err SHALL be tied to 0, the digit checking logic is omitted, and BIN behaviour is unchanged.

Verification
REQ-027 rst_n=0 pulse mid-run, DEC=16'h1234 -> all outputs 0 immediately, no ok afterwards.
REQ-028 DEC=16'h9999, st one cycle -> ok pulses 9 cycles later and BIN=14'd9999; DEC=16'h0000 -> BIN=0; DEC=16'h4095 -> BIN=4095.
REQ-029 st with DEC=16'h1234, DEC changed to 16'h5678 next cycle -> BIN=1234.
REQ-030 st with 16'h1234, then st at E4 with 16'h0007 -> single ok 9 cycles after the second st, BIN=7.
REQ-031 st asserted on the FIN exit edge -> no ok; previous BIN held; next ok 9 cycles later.
REQ-032 DEC=16'h12A4:
- with BCD_CHECK_EN -> err=1 with ok, BIN=1304;
- without BCD_CHECK_EN -> err=0, BIN=1304.
